// File: rtl/ovl_change_window_mc.sv
// ovl_change_window_mc: multi-channel change-window checker.
// After a start event on channel c, test_expr[c] must change within
// MIN_CKS..MAX_CKS clocks; early/late/restart violations pulse for one cycle
// and are summed into a saturating error counter.
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   enable                    global enable; low aborts every open window
//   start_event[NUM_CH]       per-channel start, level-sampled
//   test_expr[NUM_CH*WIDTH]   channel c at bits [c*WIDTH +: WIDTH]
//   fire_early/late/restart   one-cycle violation pulses per channel
//   busy[NUM_CH]              window open
//   err_count[CNT_W]          saturating total of fire pulses
// Optional (macro OVL_CHANGE_COVER_EN):
//   cover_pass[NUM_CH]        one-cycle pulse per passing window
//   cover_count[CNT_W]        saturating count of passes
module ovl_change_window_mc #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned MIN_CKS        = 1,
    parameter int unsigned MAX_CKS        = 8,
    parameter int unsigned NEW_START_MODE = 0,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         start_event,
    input  logic [NUM_CH*WIDTH-1:0]   test_expr,
    output logic [NUM_CH-1:0]         fire_early,
    output logic [NUM_CH-1:0]         fire_late,
    output logic [NUM_CH-1:0]         fire_restart,
    output logic [NUM_CH-1:0]         busy,
    output logic [CNT_W-1:0]          err_count
`ifdef OVL_CHANGE_COVER_EN
    ,
    output logic [NUM_CH-1:0]         cover_pass,
    output logic [CNT_W-1:0]          cover_count
`endif
);

    localparam int unsigned CW = $clog2(MAX_CKS + 1);
    localparam int unsigned SW = $clog2(3 * NUM_CH + 1);
    localparam int unsigned AW = ((CNT_W > SW) ? CNT_W : SW) + 1;

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t           state_q [NUM_CH];
    logic [WIDTH-1:0] ref_q   [NUM_CH];
    logic [CW-1:0]    cnt_q   [NUM_CH];

    logic [NUM_CH-1:0] early_c, late_c, pass_c, restart_c, verdict_c;
    logic [SW-1:0]     fire_sum_c;
    logic [AW-1:0]     err_next_c;
`ifdef OVL_CHANGE_COVER_EN
    logic [SW-1:0]     pass_sum_c;
    logic [AW-1:0]     cov_next_c;
`endif

    // Per-channel verdicts for this edge and the saturated error total.
    always_comb begin
        early_c    = '0;
        late_c     = '0;
        pass_c     = '0;
        restart_c  = '0;
        verdict_c  = '0;
        fire_sum_c = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (enable && state_q[c] == S_WAIT) begin
                if (test_expr[c*WIDTH +: WIDTH] != ref_q[c]) begin
                    if (cnt_q[c] < CW'(MIN_CKS)) early_c[c] = 1'b1;
                    else                         pass_c[c]  = 1'b1;
                end else if (cnt_q[c] == CW'(MAX_CKS)) begin
                    late_c[c] = 1'b1;
                end
                // A verdict outranks a restart in the same edge.
                restart_c[c] = (NEW_START_MODE == 2) && start_event[c]
                               && !(early_c[c] || pass_c[c] || late_c[c]);
            end
            verdict_c[c] = early_c[c] || pass_c[c] || late_c[c];
            fire_sum_c   = fire_sum_c + SW'(early_c[c]) + SW'(late_c[c])
                           + SW'(restart_c[c]);
        end
        err_next_c = AW'(err_count) + AW'(fire_sum_c);
        if (err_next_c > AW'({CNT_W{1'b1}})) err_next_c = AW'({CNT_W{1'b1}});
`ifdef OVL_CHANGE_COVER_EN
        pass_sum_c = '0;
        for (int c = 0; c < NUM_CH; c++) pass_sum_c = pass_sum_c + SW'(pass_c[c]);
        cov_next_c = AW'(cover_count) + AW'(pass_sum_c);
        if (cov_next_c > AW'({CNT_W{1'b1}})) cov_next_c = AW'({CNT_W{1'b1}});
`endif
    end

    // Channel FSMs, registered pulses and counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            fire_early   <= '0;
            fire_late    <= '0;
            fire_restart <= '0;
            busy         <= '0;
            err_count    <= '0;
`ifdef OVL_CHANGE_COVER_EN
            cover_pass   <= '0;
            cover_count  <= '0;
`endif
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= S_IDLE;
                ref_q[c]   <= '0;
                cnt_q[c]   <= '0;
            end
        end else begin
            fire_early   <= early_c;
            fire_late    <= late_c;
            fire_restart <= restart_c;
            err_count    <= CNT_W'(err_next_c);
`ifdef OVL_CHANGE_COVER_EN
            cover_pass   <= pass_c;
            cover_count  <= CNT_W'(cov_next_c);
`endif
            for (int c = 0; c < NUM_CH; c++) begin
                if (!enable) begin
                    state_q[c] <= S_IDLE;
                    busy[c]    <= 1'b0;
                end else if (start_event[c] && (state_q[c] == S_IDLE || verdict_c[c]
                                                || NEW_START_MODE == 1)) begin
                    // Arm from idle, re-arm after a verdict, or mode-1 restart.
                    state_q[c] <= S_WAIT;
                    busy[c]    <= 1'b1;
                    ref_q[c]   <= test_expr[c*WIDTH +: WIDTH];
                    cnt_q[c]   <= CW'(1);
                end else if (state_q[c] == S_WAIT) begin
                    if (verdict_c[c]) begin
                        state_q[c] <= S_IDLE;
                        busy[c]    <= 1'b0;
                    end else begin
                        cnt_q[c]   <= cnt_q[c] + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ovl_change_window_mc.sv
// Bench for ovl_change_window_mc: four instances (mode 0, mode 1, mode 2,
// mode 0 with a 2-bit error counter) share one stimulus stream. A timestamp
// model predicts every output each cycle; literal checks pin key scenarios.
module tb_ovl_change_window_mc;

    localparam int NCH  = 2;
    localparam int W    = 4;
    localparam int MINC = 2;
    localparam int MAXC = 5;
    localparam int NI   = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] start;
    logic [7:0] expr;

    logic [1:0]  fe [NI];
    logic [1:0]  fl [NI];
    logic [1:0]  fr [NI];
    logic [1:0]  bz [NI];
    logic [15:0] ec0, ec1, ec2;
    logic [1:0]  ec3;
`ifdef OVL_CHANGE_COVER_EN
    logic [1:0]  cp [NI];
    logic [15:0] cc0, cc1, cc2;
    logic [1:0]  cc3;
`endif

    int nvec = 0;
    int nerr = 0;
    bit check_en = 1'b0;

    initial forever #5 clock = ~clock;

    ovl_change_window_mc #(.NUM_CH(NCH), .WIDTH(W), .MIN_CKS(MINC), .MAX_CKS(MAXC),
                           .NEW_START_MODE(0), .CNT_W(16)) u0 (
        .clock(clock), .reset(reset), .enable(enable), .start_event(start),
        .test_expr(expr), .fire_early(fe[0]), .fire_late(fl[0]),
        .fire_restart(fr[0]), .busy(bz[0]), .err_count(ec0)
`ifdef OVL_CHANGE_COVER_EN
        , .cover_pass(cp[0]), .cover_count(cc0)
`endif
    );
    ovl_change_window_mc #(.NUM_CH(NCH), .WIDTH(W), .MIN_CKS(MINC), .MAX_CKS(MAXC),
                           .NEW_START_MODE(1), .CNT_W(16)) u1 (
        .clock(clock), .reset(reset), .enable(enable), .start_event(start),
        .test_expr(expr), .fire_early(fe[1]), .fire_late(fl[1]),
        .fire_restart(fr[1]), .busy(bz[1]), .err_count(ec1)
`ifdef OVL_CHANGE_COVER_EN
        , .cover_pass(cp[1]), .cover_count(cc1)
`endif
    );
    ovl_change_window_mc #(.NUM_CH(NCH), .WIDTH(W), .MIN_CKS(MINC), .MAX_CKS(MAXC),
                           .NEW_START_MODE(2), .CNT_W(16)) u2 (
        .clock(clock), .reset(reset), .enable(enable), .start_event(start),
        .test_expr(expr), .fire_early(fe[2]), .fire_late(fl[2]),
        .fire_restart(fr[2]), .busy(bz[2]), .err_count(ec2)
`ifdef OVL_CHANGE_COVER_EN
        , .cover_pass(cp[2]), .cover_count(cc2)
`endif
    );
    ovl_change_window_mc #(.NUM_CH(NCH), .WIDTH(W), .MIN_CKS(MINC), .MAX_CKS(MAXC),
                           .NEW_START_MODE(0), .CNT_W(2)) u3 (
        .clock(clock), .reset(reset), .enable(enable), .start_event(start),
        .test_expr(expr), .fire_early(fe[3]), .fire_late(fl[3]),
        .fire_restart(fr[3]), .busy(bz[3]), .err_count(ec3)
`ifdef OVL_CHANGE_COVER_EN
        , .cover_pass(cp[3]), .cover_count(cc3)
`endif
    );

    // Model state: window open flag, start timestamp and reference value.
    int         cyc = 0;
    bit         open_m [NI][NCH];
    int         st_m   [NI][NCH];
    logic [3:0] ref_m  [NI][NCH];
    logic [1:0] efe [NI], efl [NI], efr [NI], ebz [NI];
    int         eec [NI];
    int         mode_i [NI] = '{0, 1, 2, 0};
    int         cmax_i [NI] = '{65535, 65535, 65535, 3};

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s u%0d: got %0h expected %0h (t=%0t)", name, idx, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ec_of(input int i);
        case (i)
            0: return ec0;
            1: return ec1;
            2: return ec2;
            default: return {14'd0, ec3};
        endcase
    endfunction

    // Elapsed clocks since start decide the verdict; no counter is modelled.
    task automatic model_step();
        logic [3:0] cur;
        int el;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            efe[i] = '0; efl[i] = '0; efr[i] = '0;
            if (reset) begin
                for (int c = 0; c < NCH; c++) open_m[i][c] = 1'b0;
                eec[i] = 0;
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    if (!enable) begin
                        open_m[i][c] = 1'b0;
                    end else begin
                        cur = expr[c*W +: W];
                        if (open_m[i][c]) begin
                            el = cyc - st_m[i][c];
                            if (cur != ref_m[i][c]) begin
                                if (el < MINC) efe[i][c] = 1'b1;
                                open_m[i][c] = 1'b0;
                            end else if (el == MAXC) begin
                                efl[i][c] = 1'b1;
                                open_m[i][c] = 1'b0;
                            end else if (start[c]) begin
                                if (mode_i[i] == 1) begin
                                    st_m[i][c] = cyc; ref_m[i][c] = cur;
                                end else if (mode_i[i] == 2) begin
                                    efr[i][c] = 1'b1;
                                end
                            end
                        end
                        if (!open_m[i][c] && start[c]) begin
                            open_m[i][c] = 1'b1; st_m[i][c] = cyc; ref_m[i][c] = cur;
                        end
                    end
                end
                eec[i] += $countones({efe[i], efl[i], efr[i]});
                if (eec[i] > cmax_i[i]) eec[i] = cmax_i[i];
            end
            ebz[i] = {open_m[i][1], open_m[i][0]};
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    // Every-cycle comparison of all instances against the model.
    initial forever begin
        @(negedge clock);
        if (check_en) begin
            for (int i = 0; i < NI; i++) begin
                chk("fire_early", i, 32'(fe[i]), 32'(efe[i]));
                chk("fire_late", i, 32'(fl[i]), 32'(efl[i]));
                chk("fire_restart", i, 32'(fr[i]), 32'(efr[i]));
                chk("busy", i, 32'(bz[i]), 32'(ebz[i]));
                chk("err_count", i, 32'(ec_of(i)), 32'(eec[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int bcnt;
        reset = 1'b1; enable = 1'b1; start = 2'b00; expr = 8'h00;
        tick();
        check_en = 1'b1;
        tick();
        chk("rst_busy", 0, 32'(bz[0]), 32'h0);
        chk("rst_err", 0, 32'(ec0), 32'h0);
        chk("rst_fire", 0, 32'({fe[0], fl[0], fr[0]}), 32'h0);
        reset = 1'b0;

        // Pass: change at E3.
        expr = 8'h03; start = 2'b01; tick();
        chk("s1_busy_e0", 0, 32'(bz[0]), 32'h1);
        start = 2'b00; ticks(2);
        expr = 8'h05; tick();
        chk("s1_busy_drop", 0, 32'(bz[0]), 32'h0);
        chk("s1_nofire", 0, 32'({fe[0], fl[0]}), 32'h0);
        chk("s1_err", 0, 32'(ec0), 32'h0);

        // Early: change at E1.
        start = 2'b01; tick();
        start = 2'b00; expr = 8'h06; tick();
        chk("s2_early", 0, 32'(fe[0]), 32'h1);
        chk("s2_err", 0, 32'(ec0), 32'h1);
        tick();
        chk("s2_early_1cyc", 0, 32'(fe[0]), 32'h0);

        // Late on ch1 with busy held five cycles.
        start = 2'b10; tick();
        start = 2'b00;
        bcnt = 0;
        for (int k = 1; k <= 5; k++) begin
            if (bz[0][1]) bcnt++;
            tick();
        end
        chk("s3_busy_cycles", 0, 32'(bcnt), 32'd5);
        chk("s3_late", 0, 32'(fl[0]), 32'h2);
        chk("s3_err", 0, 32'(ec0), 32'h2);

        // Both channels late together; u3 saturates at 3.
        start = 2'b11; tick();
        start = 2'b00; ticks(5);
        chk("s4_late_both", 0, 32'(fl[0]), 32'h3);
        chk("s4_err", 0, 32'(ec0), 32'h4);
        chk("s4_sat", 3, 32'(ec3), 32'h3);
        start = 2'b11; tick();
        start = 2'b00; ticks(5);
        chk("s4_err2", 0, 32'(ec0), 32'h6);
        chk("s4_sat_hold", 3, 32'(ec3), 32'h3);

        // Start again at E4: mode 0 ignores, 1 restarts, 2 flags.
        start = 2'b01; tick();
        start = 2'b00; ticks(3);
        start = 2'b01; tick();
        start = 2'b00;
        chk("s5_restart_m2", 2, 32'(fr[2]), 32'h1);
        chk("s5_restart_m1", 1, 32'(fr[1]), 32'h0);
        tick();
        chk("s5_late_m2", 2, 32'(fl[2]), 32'h1);
        chk("s5_late_m0", 0, 32'(fl[0]), 32'h1);
        chk("s5_nolate_m1", 1, 32'(fl[1]), 32'h0);
        chk("s5_busy_m1", 1, 32'(bz[1]), 32'h1);
        ticks(4);
        chk("s5_late_m1_e9", 1, 32'(fl[1]), 32'h1);

        // Enable dropped at E3 aborts quietly.
        start = 2'b01; tick();
        start = 2'b00; ticks(2);
        enable = 1'b0; tick();
        chk("s6_busy", 0, 32'(bz[0]), 32'h0);
        chk("s6_nofire", 0, 32'({fe[0], fl[0]}), 32'h0);
        enable = 1'b1; ticks(6);
        chk("s6_nolate", 0, 32'(fl[0]), 32'h0);

        // Reset at E2 clears everything.
        start = 2'b11; tick();
        start = 2'b00; tick();
        reset = 1'b1; tick();
        chk("s7_busy", 0, 32'(bz[0]), 32'h0);
        chk("s7_err", 0, 32'(ec0), 32'h0);
        chk("s7_fire", 0, 32'({fe[0], fl[0], fr[0]}), 32'h0);
        reset = 1'b0;

        // Change exactly at E5 passes.
        expr = 8'h03; start = 2'b01; tick();
        start = 2'b00; ticks(4);
        expr = 8'h04; tick();
        chk("s8_max_pass", 0, 32'(fl[0]), 32'h0);
        chk("s8_busy", 0, 32'(bz[0]), 32'h0);

        // Pass at E2 with start re-arms; then late on the new window.
        start = 2'b01; tick();
        start = 2'b00; tick();
        expr = 8'h07; start = 2'b01; tick();
        chk("s9_rearm_busy", 0, 32'(bz[0]), 32'h1);
        chk("s9_no_restart", 2, 32'(fr[2]), 32'h0);
        start = 2'b00; ticks(5);
        chk("s9_late", 0, 32'(fl[0]), 32'h1);

        ticks(3);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
